// File: rtl/word_burst_bridge_pkg.sv
// Shared types and sizes for the word-to-line burst bridge.
// Holds the FSM state enum, line/beat geometry and the beat-counter width.
package bridge_pkg;

    localparam int LINE_BITS   = 256;
    localparam int BEAT_BITS   = 64;
    localparam int OFFSET_BITS = 5;
    localparam int CNT_BITS    = 2;

    typedef logic [LINE_BITS-1:0] line_t;
    typedef logic [BEAT_BITS-1:0] beat_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_BURST,
        MERGE,
        WR_BURST,
        RESP
    } bridge_state_t;

endpackage

// File: rtl/word_burst_bridge_if.sv
// Bus bundles for the bridge: core word port and 64-bit burst memory port.
// core_mem_if: master=core, slave=bridge. pmem_if: master=bridge, slave=memory.
interface core_mem_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    modport master (
        output mem_read, mem_write, mem_address,
        output mem_byte_enable, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport slave (
        input  mem_read, mem_write, mem_address,
        input  mem_byte_enable, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

interface pmem_if;
    logic [31:0] pmem_address;
    logic        pmem_read;
    logic        pmem_write;
    logic [63:0] pmem_wdata;
    logic [63:0] pmem_rdata;
    logic        pmem_resp;

    modport master (
        output pmem_address, pmem_read, pmem_write, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport slave (
        input  pmem_address, pmem_read, pmem_write, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/word_burst_bridge_line_merge.sv
// Combinational byte-lane merge of one 32-bit word into a 256-bit line.
// Ports: line_i, word_idx_i, be_i, wdata_i in; line_o (merged line) out.
module line_merge
    import bridge_pkg::*;
(
    input  line_t       line_i,
    input  logic [2:0]  word_idx_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output line_t       line_o
);

    always_comb begin
        line_o = line_i;
        for (int i = 0; i < 4; i++) begin
            if (be_i[i]) begin
                line_o[int'(word_idx_i) * 32 + 8 * i +: 8] =
                    wdata_i[8 * i +: 8];
            end
        end
    end

endmodule

// File: rtl/word_burst_bridge.sv
// Turns single-word core reads/writes into 4-beat 256-bit line bursts (RMW on store).
// Ports: clk, rst (sync, active-high), core (core_mem_if.slave), pmem (pmem_if.master).
module word_burst_bridge
    import bridge_pkg::*;
#(
    parameter int LINE_BEATS = 4
) (
    input  logic       clk,
    input  logic       rst,
    core_mem_if.slave  core,
    pmem_if.master     pmem
);

    bridge_state_t        state_q, state_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic [31:2]          addr_q, addr_d;
    logic [3:0]           be_q, be_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 wr_q, wr_d;
    line_t                line_q, line_d;
    line_t                merged;
    logic                 last_beat;
    logic                 unused_addr;

    // Word alignment is the core's job; low address bits carry nothing here.
    assign unused_addr = ^core.mem_address[1:0];

    assign last_beat = (cnt_q == CNT_BITS'(LINE_BEATS - 1));

    line_merge u_merge (
        .line_i     (line_q),
        .word_idx_i (addr_q[4:2]),
        .be_i       (be_q),
        .wdata_i    (wdata_q),
        .line_o     (merged)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        line_d  = line_q;
        unique case (state_q)
            IDLE: begin
                if (core.mem_read | core.mem_write) begin
                    addr_d  = core.mem_address[31:2];
                    be_d    = core.mem_byte_enable;
                    wdata_d = core.mem_wdata;
                    // write wins when both requests are raised
                    wr_d    = core.mem_write;
                    cnt_d   = '0;
                    state_d = RD_BURST;
                end
            end
            RD_BURST: begin
                if (pmem.pmem_resp) begin
                    line_d[{cnt_q, 6'b0} +: BEAT_BITS] = pmem.pmem_rdata;
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) begin
                        // an all-lanes-off store changes nothing: skip write-back
                        state_d = (wr_q && be_q != 4'b0) ? MERGE : RESP;
                    end
                end
            end
            MERGE: begin
                line_d  = merged;
                cnt_d   = '0;
                state_d = WR_BURST;
            end
            WR_BURST: begin
                if (pmem.pmem_resp) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            line_q  <= line_d;
        end
    end

    assign core.mem_resp    = (state_q == RESP);
    assign core.mem_rdata   = line_q[{addr_q[4:2], 5'b0} +: 32];
    assign pmem.pmem_read   = (state_q == RD_BURST);
    assign pmem.pmem_write  = (state_q == WR_BURST);
    assign pmem.pmem_wdata  = line_q[{cnt_q, 6'b0} +: BEAT_BITS];
    assign pmem.pmem_address = {addr_q[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

endmodule

// File: tb/tb_word_burst_bridge.sv
// Scoreboard bench for word_burst_bridge: directed word requests, burst memory model.
// Expected read words and write beats are queued at issue and checked by monitors.
module tb_word_burst_bridge;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    core_mem_if core_bus ();
    pmem_if     pmem_bus ();

    word_burst_bridge #(.LINE_BEATS(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .core (core_bus.slave),
        .pmem (pmem_bus.master)
    );

    int vecs = 0;
    int miss = 0;

    logic [31:0]  exp_rd_q[$];
    logic [63:0]  exp_wb_q[$];
    logic [255:0] mem_line = '0;
    logic [31:0]  exp_addr = '0;
    bit           rand_wait = 0;
    bit           abort_req = 0;
    int           pw_cycles = 0;

    function automatic void chk(string name, logic [63:0] act,
                                logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic int next_wait();
        return rand_wait ? int'($urandom_range(0, 3)) : 0;
    endfunction

    // Burst memory: first read beat one cycle after pmem_read rises,
    // write beats accepted as soon as pmem_write is seen, optional waits.
    int beat = 0;
    int wait_left = 0;
    bit rd_seen = 0;

    always @(negedge clk) begin
        pmem_bus.pmem_resp = 1'b0;
        if (pmem_bus.pmem_read === 1'b1) begin
            if (!rd_seen) begin
                rd_seen = 1;
                chk("pmem_address", pmem_bus.pmem_address, exp_addr);
            end else if (wait_left > 0) begin
                wait_left--;
            end else begin
                if (abort_req && beat == 1) begin
                    rst = 1'b1;
                    abort_req = 0;
                end
                pmem_bus.pmem_rdata = mem_line[beat * 64 +: 64];
                pmem_bus.pmem_resp  = 1'b1;
                beat = (beat + 1) % 4;
                wait_left = next_wait();
            end
        end else if (pmem_bus.pmem_write === 1'b1) begin
            if (wait_left > 0) begin
                wait_left--;
            end else begin
                if (exp_wb_q.size() == 0) begin
                    vecs++;
                    miss++;
                    $display("FAIL unexpected_wbeat: got %h expected none",
                             pmem_bus.pmem_wdata);
                end else begin
                    chk("pmem_wdata", pmem_bus.pmem_wdata,
                        exp_wb_q.pop_front());
                end
                pmem_bus.pmem_resp = 1'b1;
                beat = (beat + 1) % 4;
                wait_left = next_wait();
            end
        end else begin
            rd_seen = 0;
            beat = 0;
            wait_left = next_wait();
        end
    end

    always @(posedge clk) begin
        if (pmem_bus.pmem_write === 1'b1) pw_cycles++;
        if (pmem_bus.pmem_read === 1'b1 && pmem_bus.pmem_write === 1'b1)
            chk("rd_wr_exclusive", 1, 0);
    end

    // Response monitor: every mem_resp pops one expected word.
    always @(posedge clk) begin
        #1;
        if (core_bus.mem_resp === 1'b1) begin
            if (exp_rd_q.size() == 0) begin
                vecs++;
                miss++;
                $display("FAIL unexpected_resp: got %h expected none",
                         core_bus.mem_rdata);
            end else begin
                chk("mem_rdata", core_bus.mem_rdata, exp_rd_q.pop_front());
            end
        end
    end

    task automatic do_req(input bit rd, input bit wr,
                          input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, input int exp_lat);
        int cyc;
        cyc = 0;
        @(negedge clk);
        exp_addr = {addr[31:5], 5'b0};
        core_bus.mem_read        = rd;
        core_bus.mem_write       = wr;
        core_bus.mem_address     = addr;
        core_bus.mem_byte_enable = be;
        core_bus.mem_wdata       = wd;
        while (core_bus.mem_resp !== 1'b1 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (core_bus.mem_resp !== 1'b1) begin
            chk("resp_timeout", cyc, exp_lat);
        end else if (exp_lat > 0) begin
            chk("resp_latency", cyc, exp_lat);
        end
        @(negedge clk);
        core_bus.mem_read  = 1'b0;
        core_bus.mem_write = 1'b0;
        @(posedge clk);
        #1;
        chk("resp_one_cycle", core_bus.mem_resp, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_mem_resp"},   core_bus.mem_resp, 0);
        chk({tag, "_pmem_read"},  pmem_bus.pmem_read, 0);
        chk({tag, "_pmem_write"}, pmem_bus.pmem_write, 0);
        chk({tag, "_mem_rdata"},  core_bus.mem_rdata, 0);
        chk({tag, "_pmem_wdata"}, pmem_bus.pmem_wdata, 0);
        chk({tag, "_pmem_addr"},  pmem_bus.pmem_address, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pw0;
        int cyc;
        core_bus.mem_read        = 1'b0;
        core_bus.mem_write       = 1'b0;
        core_bus.mem_address     = '0;
        core_bus.mem_byte_enable = '0;
        core_bus.mem_wdata       = '0;
        pmem_bus.pmem_rdata      = '0;
        pmem_bus.pmem_resp       = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Read 0x44 -> word 1 (beat0 upper half)
        mem_line = {64'h8888_8888_7777_7777, 64'h6666_6666_5555_5555,
                    64'h4444_4444_3333_3333, 64'h2222_2222_1111_1111};
        exp_rd_q.push_back(32'h2222_2222);
        do_req(1, 0, 32'h0000_0044, 4'b0000, 32'h0, 6);

        // Write 0xAABBCCDD, be 0101 at 0x48 -> word 2 = 0x11223344
        mem_line = {64'h0F0F_0F0F_F0F0_F0F0, 64'hDEAD_BEEF_CAFE_F00D,
                    64'h5566_7788_1122_3344, 64'h0123_4567_89AB_CDEF};
        exp_wb_q.push_back(64'h0123_4567_89AB_CDEF);
        exp_wb_q.push_back(64'h5566_7788_11BB_33DD);
        exp_wb_q.push_back(64'hDEAD_BEEF_CAFE_F00D);
        exp_wb_q.push_back(64'h0F0F_0F0F_F0F0_F0F0);
        exp_rd_q.push_back(32'h11BB_33DD);
        do_req(0, 1, 32'h0000_0048, 4'b0101, 32'hAABB_CCDD, 11);

        // Write with no lanes at 0x1C: read burst only, word 7 returned
        pw0 = pw_cycles;
        exp_rd_q.push_back(32'h0F0F_0F0F);
        do_req(0, 1, 32'h0000_001C, 4'b0000, 32'hFFFF_FFFF, 6);
        chk("be0_no_write", pw_cycles - pw0, 0);

        // Random wait states; word k of the line is 0x1000_000k
        rand_wait = 1;
        mem_line = {64'h1000_0007_1000_0006, 64'h1000_0005_1000_0004,
                    64'h1000_0003_1000_0002, 64'h1000_0001_1000_0000};
        exp_rd_q.push_back(32'h1000_0007);
        do_req(1, 0, 32'h8000_003C, 4'b0000, 32'h0, 0);
        exp_rd_q.push_back(32'h1000_0002);
        do_req(1, 0, 32'h8000_0028, 4'b0000, 32'h0, 0);
        exp_rd_q.push_back(32'h1000_0005);
        do_req(1, 0, 32'h0000_1014, 4'b0000, 32'h0, 0);

        exp_wb_q.push_back(64'h1000_0001_1000_0000);
        exp_wb_q.push_back(64'h1000_0003_1000_0002);
        exp_wb_q.push_back(64'hCAFE_BA05_1000_0004);
        exp_wb_q.push_back(64'h1000_0007_1000_0006);
        exp_rd_q.push_back(32'hCAFE_BA05);
        do_req(0, 1, 32'h8000_0034, 4'b1110, 32'hCAFE_BABE, 0);

        exp_wb_q.push_back(64'h1000_0001_7700_0000);
        exp_wb_q.push_back(64'h1000_0003_1000_0002);
        exp_wb_q.push_back(64'h1000_0005_1000_0004);
        exp_wb_q.push_back(64'h1000_0007_1000_0006);
        exp_rd_q.push_back(32'h7700_0000);
        do_req(0, 1, 32'h0000_0000, 4'b1000, 32'h7766_5544, 0);
        rand_wait = 0;

        // Reset on the 2nd read beat of a store; burst is abandoned
        abort_req = 1;
        @(negedge clk);
        exp_addr = 32'h0000_0040;
        core_bus.mem_write       = 1'b1;
        core_bus.mem_address     = 32'h0000_0048;
        core_bus.mem_byte_enable = 4'b1111;
        core_bus.mem_wdata       = 32'h1234_5678;
        cyc = 0;
        while (rst !== 1'b1 && cyc < 50) begin
            @(posedge clk);
            cyc++;
        end
        chk("abort_reached", rst, 1);
        #1;
        check_idle_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        core_bus.mem_write = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_not_resumed", pmem_bus.pmem_read, 0);

        // Fresh read after reset
        exp_rd_q.push_back(32'h1000_0001);
        do_req(1, 0, 32'h0000_0204, 4'b0000, 32'h0, 6);

        // Both read and write high: full RMW store to word 2
        exp_wb_q.push_back(64'h1000_0001_1000_0000);
        exp_wb_q.push_back(64'h1000_0003_0BAD_F00D);
        exp_wb_q.push_back(64'h1000_0005_1000_0004);
        exp_wb_q.push_back(64'h1000_0007_1000_0006);
        exp_rd_q.push_back(32'h0BAD_F00D);
        do_req(1, 1, 32'h0000_0008, 4'b1111, 32'h0BAD_F00D, 11);

        repeat (4) @(posedge clk);
        #1;
        chk("rd_queue_drained", exp_rd_q.size(), 0);
        chk("wb_queue_drained", exp_wb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
